// File: rtl/ball_engine.sv
// ball_engine: frame-driven pong ball motion, racket/wall collision, speed ramp,
// scoring and game-over detection. All state advances on the end_of_frame pulse.
module ball_engine #(
  parameter int X_LEFT_BOUNCE  = 100,
  parameter int X_RIGHT_BOUNCE = 923,
  parameter int Y_TOP          = 51,
  parameter int Y_BOTTOM       = 717,
  parameter int BALL_SIZE      = 15,
  parameter int RACKET_H       = 80,
  parameter int SPEED_INIT     = 5,
  parameter int SPEED_MAX      = 9,
  parameter int HITS_PER_STEP  = 4,
  parameter int WIN_SCORE      = 11,
  parameter int X_CENTER       = 504,
  parameter int Y_CENTER       = 376,
  parameter int X_MIN          = 6,
  parameter int X_MAX          = 1017
) (
  input  logic        clk65MHz,
  input  logic        rst,
  input  logic        end_of_frame,
  input  logic        serve,
  input  logic        game_enable,
  input  logic        mode_multi,
  input  logic [9:0]  pos_of_player_1,
  input  logic [9:0]  pos_of_player_2,
  output logic [10:0] x_pos_of_ball,
  output logic [10:0] y_pos_of_ball,
  output logic [3:0]  points_player_1,
  output logic [3:0]  points_player_2,
  output logic        game_over,
  output logic        winner
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SERVE     = 3'd1;
  localparam logic [2:0] FLY       = 3'd2;
  localparam logic [2:0] SCORED    = 3'd3;
  localparam logic [2:0] GAME_OVER = 3'd4;

  // Vertical direction is a 2-bit two's-complement value: -1, 0 or +1.
  localparam logic [1:0] DY_UP   = 2'b11;
  localparam logic [1:0] DY_NONE = 2'b00;
  localparam logic [1:0] DY_DOWN = 2'b01;

  localparam logic signed [11:0] LEFT_FACE    = 12'(X_LEFT_BOUNCE);
  localparam logic signed [11:0] RIGHT_FACE   = 12'(X_RIGHT_BOUNCE - BALL_SIZE);
  localparam logic signed [11:0] TOP_LIMIT    = 12'(Y_TOP);
  localparam logic signed [11:0] BOTTOM_LIMIT = 12'(Y_BOTTOM - BALL_SIZE);
  localparam logic signed [11:0] BALL         = 12'(BALL_SIZE);
  localparam logic signed [11:0] RACKET       = 12'(RACKET_H);
  localparam logic signed [11:0] THIRD_1      = 12'(RACKET_H / 3);
  localparam logic signed [11:0] THIRD_2      = 12'((2 * RACKET_H) / 3);
  localparam logic signed [11:0] EXIT_LEFT    = 12'(X_MIN);
  localparam logic signed [11:0] EXIT_RIGHT   = 12'(X_MAX);
  localparam logic [10:0]        CENTER_X     = 11'(X_CENTER);
  localparam logic [10:0]        CENTER_Y     = 11'(Y_CENTER);
  localparam logic [3:0]         SPEED_START  = 4'(SPEED_INIT);
  localparam logic [3:0]         SPEED_TOP    = 4'(SPEED_MAX);
  localparam logic [7:0]         STEP_HITS    = 8'(HITS_PER_STEP);
  localparam logic [3:0]         SCORE_WIN    = 4'(WIN_SCORE);

  logic [2:0]  state;
  logic [10:0] x;
  logic [10:0] y;
  logic        dx_neg;
  logic [1:0]  dy;
  logic [3:0]  speed;
  logic [7:0]  hits;
  logic        scorer_p2;
  logic [3:0]  score_1;
  logic [3:0]  score_2;
  logic        over;
  logic        win;

  logic signed [11:0] x_s;
  logic signed [11:0] y_s;
  logic signed [11:0] stride;
  logic signed [11:0] cand_x;
  logic signed [11:0] cand_y;
  logic signed [11:0] racket_top;
  logic signed [11:0] racket_offset;
  logic [10:0]        wall_y;
  logic [1:0]         wall_dy;
  logic [1:0]         racket_dy;
  logic               racket_hit;
  logic               at_right;
  logic               at_left;
  logic [10:0]        exit_x;
  logic               exit_hit;
  logic [7:0]         hits_next;
  logic [3:0]         speed_next;

  // Candidate position for this frame plus wall, racket and exit-bound decisions.
  // The racket test deliberately uses the current y, not the wall-adjusted one.
  always_comb begin
    x_s    = $signed({1'b0, x});
    y_s    = $signed({1'b0, y});
    stride = $signed({8'd0, speed});
    cand_x = dx_neg ? (x_s - stride) : (x_s + stride);
    case (dy)
      DY_UP:   cand_y = y_s - stride;
      DY_DOWN: cand_y = y_s + stride;
      default: cand_y = y_s;
    endcase

    wall_y  = cand_y[10:0];
    wall_dy = dy;
    if (dy == DY_UP && cand_y <= TOP_LIMIT) begin
      wall_y  = TOP_LIMIT[10:0];
      wall_dy = DY_DOWN;
    end else if (dy == DY_DOWN && cand_y >= BOTTOM_LIMIT) begin
      wall_y  = BOTTOM_LIMIT[10:0];
      wall_dy = DY_UP;
    end

    racket_top    = dx_neg ? $signed({2'b00, pos_of_player_2})
                           : $signed({2'b00, pos_of_player_1});
    racket_offset = y_s + BALL - racket_top;
    racket_hit    = (racket_offset >= 12'sd0) && (y_s <= racket_top + RACKET);
    if (racket_offset < THIRD_1) begin
      racket_dy = DY_UP;
    end else if (racket_offset < THIRD_2) begin
      racket_dy = DY_NONE;
    end else begin
      racket_dy = DY_DOWN;
    end

    at_right = !dx_neg && (cand_x >= RIGHT_FACE);
    at_left  = dx_neg && (cand_x <= LEFT_FACE);

    exit_x   = cand_x[10:0];
    exit_hit = 1'b0;
    if (cand_x < EXIT_LEFT) begin
      exit_x   = EXIT_LEFT[10:0];
      exit_hit = 1'b1;
    end else if (cand_x > EXIT_RIGHT) begin
      exit_x   = EXIT_RIGHT[10:0];
      exit_hit = 1'b1;
    end
  end

  // Speed ramp: every HITS_PER_STEP racket returns add one pixel/frame, up to the cap.
  always_comb begin
    hits_next  = hits + 8'd1;
    speed_next = speed;
    if (hits_next == STEP_HITS) begin
      hits_next = 8'd0;
      if (speed < SPEED_TOP) begin
        speed_next = speed + 4'd1;
      end
    end
  end

  // Game state machine; disabling the game is a full return to the reset state.
  // The serve direction needs no explicit update: the ball leaves the field still
  // travelling toward the loser's side, which is the direction of the next serve.
  always_ff @(posedge clk65MHz) begin
    if (rst || !game_enable) begin
      state     <= IDLE;
      x         <= CENTER_X;
      y         <= CENTER_Y;
      dx_neg    <= 1'b0;
      dy        <= DY_NONE;
      speed     <= SPEED_START;
      hits      <= 8'd0;
      scorer_p2 <= 1'b0;
      score_1   <= 4'd0;
      score_2   <= 4'd0;
      over      <= 1'b0;
      win       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= SERVE;
        end
        SERVE: begin
          x     <= CENTER_X;
          y     <= CENTER_Y;
          dy    <= DY_NONE;
          speed <= SPEED_START;
          hits  <= 8'd0;
          if (serve) begin
            state <= FLY;
          end
        end
        FLY: begin
          if (end_of_frame) begin
            x  <= cand_x[10:0];
            y  <= wall_y;
            dy <= wall_dy;
            if (at_right || (at_left && mode_multi)) begin
              if (racket_hit) begin
                x      <= dx_neg ? LEFT_FACE[10:0] : RIGHT_FACE[10:0];
                dx_neg <= !dx_neg;
                dy     <= racket_dy;
                hits   <= hits_next;
                speed  <= speed_next;
              end else begin
                state     <= SCORED;
                scorer_p2 <= !dx_neg;
                if (dx_neg) begin
                  if (score_1 != SCORE_WIN) begin
                    score_1 <= score_1 + 4'd1;
                  end
                end else begin
                  if (score_2 != SCORE_WIN) begin
                    score_2 <= score_2 + 4'd1;
                  end
                end
              end
            end else if (at_left) begin
              x      <= LEFT_FACE[10:0];
              dx_neg <= 1'b0;
            end
          end
        end
        SCORED: begin
          if (end_of_frame) begin
            x  <= exit_x;
            y  <= wall_y;
            dy <= wall_dy;
            if (exit_hit) begin
              if ((scorer_p2 ? score_2 : score_1) == SCORE_WIN) begin
                state <= GAME_OVER;
                over  <= 1'b1;
                win   <= scorer_p2;
              end else begin
                state <= SERVE;
              end
            end
          end
        end
        GAME_OVER: begin
          state <= GAME_OVER;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign x_pos_of_ball   = x;
  assign y_pos_of_ball   = y;
  assign points_player_1 = score_1;
  assign points_player_2 = score_2;
  assign game_over       = over;
  assign winner          = win;

endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: directed and randomized scenarios for ball_engine, checked against
// a frame-level reference model of the pong rules kept in this file.
module tb_ball_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        end_of_frame;
  logic        serve;
  logic        game_enable;
  logic        mode_multi;
  logic [9:0]  p1;
  logic [9:0]  p2;
  logic [10:0] x_pos;
  logic [10:0] y_pos;
  logic [3:0]  pts1;
  logic [3:0]  pts2;
  logic        game_over;
  logic        winner;

  int n_tests = 0;
  int n_fail  = 0;

  ball_engine dut (
    .clk65MHz        (clk),
    .rst             (rst),
    .end_of_frame    (end_of_frame),
    .serve           (serve),
    .game_enable     (game_enable),
    .mode_multi      (mode_multi),
    .pos_of_player_1 (p1),
    .pos_of_player_2 (p2),
    .x_pos_of_ball   (x_pos),
    .y_pos_of_ball   (y_pos),
    .points_player_1 (pts1),
    .points_player_2 (pts2),
    .game_over       (game_over),
    .winner          (winner)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Reference model: one call per clock edge, using the inputs about to be sampled.
  localparam int M_IDLE = 0, M_SERVE = 1, M_FLY = 2, M_SCORED = 3, M_OVER = 4;
  int m_state, m_x, m_y, m_dx, m_dy, m_speed, m_hits, m_s1, m_s2, m_scorer, m_over, m_win;

  function automatic int zone_dy(input int d);
    if (d < 80 / 3) return -1;
    if (d < (2 * 80) / 3) return 0;
    return 1;
  endfunction

  task automatic model_new_game();
    m_state = M_IDLE; m_x = 504; m_y = 376; m_dx = 1; m_dy = 0; m_speed = 5;
    m_hits = 0; m_s1 = 0; m_s2 = 0; m_scorer = 0; m_over = 0; m_win = 0;
  endtask

  task automatic model_enter_serve();
    m_state = M_SERVE; m_dy = 0; m_speed = 5; m_hits = 0;
    m_dx = (m_scorer == 1) ? -1 : 1;
  endtask

  task automatic model_edge();
    int cx, cy, ny, ndy, p;
    bit exited;
    if (rst || !game_enable) begin
      model_new_game();
      return;
    end
    case (m_state)
      M_IDLE: model_enter_serve();
      M_SERVE: begin
        m_x = 504; m_y = 376;
        if (serve) m_state = M_FLY;
      end
      M_FLY, M_SCORED: begin
        if (end_of_frame) begin
          cx = m_x + m_dx * m_speed;
          cy = m_y + m_dy * m_speed;
          ny = cy; ndy = m_dy;
          if (m_dy == -1 && cy <= 51) begin ny = 51; ndy = 1; end
          else if (m_dy == 1 && cy >= 702) begin ny = 702; ndy = -1; end
          if (m_state == M_SCORED) begin
            exited = 0;
            if (cx > 1017) begin cx = 1017; exited = 1; end
            else if (cx < 6) begin cx = 6; exited = 1; end
            m_x = cx; m_y = ny; m_dy = ndy;
            if (exited) begin
              if (((m_scorer == 1) ? m_s1 : m_s2) == 11) begin
                m_state = M_OVER; m_over = 1; m_win = (m_scorer == 2) ? 1 : 0;
              end else begin
                model_enter_serve();
              end
            end
          end else begin
            m_x = cx;
            if ((m_dx == 1 && cx >= 908) || (m_dx == -1 && cx <= 100)) begin
              if (m_dx == -1 && !mode_multi) begin
                m_x = 100; m_dx = 1;
              end else begin
                p = (m_dx == 1) ? int'(p1) : int'(p2);
                if (m_y + 15 >= p && m_y <= p + 80) begin
                  m_x = (m_dx == 1) ? 908 : 100;
                  m_dx = -m_dx;
                  ndy = zone_dy(m_y + 15 - p);
                  m_hits++;
                  if (m_hits == 4) begin
                    m_hits = 0;
                    if (m_speed < 9) m_speed++;
                  end
                end else begin
                  if (m_dx == 1) begin m_scorer = 2; if (m_s2 < 11) m_s2++; end
                  else begin m_scorer = 1; if (m_s1 < 11) m_s1++; end
                  m_state = M_SCORED;
                end
              end
            end
            m_y = ny; m_dy = ndy;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    end_of_frame = 1'b1;
    tick();
    end_of_frame = 1'b0;
    tick();
  endtask

  task automatic start_game(input bit multi, input int rp1, input int rp2);
    rst = 1'b1; game_enable = 1'b1; serve = 1'b0; end_of_frame = 1'b0;
    mode_multi = multi; p1 = 10'(rp1); p2 = 10'(rp2);
    tick();
    rst = 1'b0;
    tick();
    tick();
    serve = 1'b1;
    tick();
    serve = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; game_enable = 1'b1; serve = 1'b1; end_of_frame = 1'b1;
    mode_multi = 1'b1; p1 = 10'd0; p2 = 10'd0;
    tick();
    tick();
    n_tests++; if (x_pos !== 11'd504) begin n_fail++; $display("[TB] FAIL reset_x: got %0d expected 504", x_pos); end
    n_tests++; if (y_pos !== 11'd376) begin n_fail++; $display("[TB] FAIL reset_y: got %0d expected 376", y_pos); end
    n_tests++; if (pts1 !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_pts1: got %0d expected 0", pts1); end
    n_tests++; if (pts2 !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_pts2: got %0d expected 0", pts2); end
    n_tests++; if (game_over !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_game_over: got %0d expected 0", game_over); end
    n_tests++; if (winner !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_winner: got %0d expected 0", winner); end
    rst = 1'b0; serve = 1'b0; end_of_frame = 1'b0;
  endtask

  task automatic test_right_hit();
    start_game(1'b1, 350, 350);
    repeat (80) frame();
    n_tests++; if (x_pos !== 11'd904) begin n_fail++; $display("[TB] FAIL hit_x80: got %0d expected 904", x_pos); end
    frame();
    n_tests++; if (x_pos !== 11'd908) begin n_fail++; $display("[TB] FAIL hit_x81: got %0d expected 908", x_pos); end
    n_tests++; if (y_pos !== 11'd376) begin n_fail++; $display("[TB] FAIL hit_y81: got %0d expected 376", y_pos); end
    n_tests++; if (pts1 !== 4'd0 || pts2 !== 4'd0) begin n_fail++; $display("[TB] FAIL hit_scores: got %0d/%0d expected 0/0", pts1, pts2); end
    frame();
    n_tests++; if (x_pos !== 11'd903) begin n_fail++; $display("[TB] FAIL hit_return_x: got %0d expected 903", x_pos); end
    n_tests++; if (y_pos !== 11'd376) begin n_fail++; $display("[TB] FAIL hit_return_y: got %0d expected 376", y_pos); end
  endtask

  task automatic test_racket_zones();
    int d_vals[7] = '{0, 25, 26, 52, 53, 95, 96};
    int exp_x[7]  = '{903, 903, 903, 903, 903, 903, 914};
    int exp_y[7]  = '{371, 371, 376, 376, 381, 381, 376};
    int exp_p2[7] = '{0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      start_game(1'b1, 391 - d_vals[i], 350);
      repeat (82) frame();
      n_tests++;
      if (x_pos !== 11'(exp_x[i]) || y_pos !== 11'(exp_y[i]) || pts2 !== 4'(exp_p2[i])) begin
        n_fail++;
        $display("[TB] FAIL zone_d%0d: got x=%0d y=%0d p2=%0d expected x=%0d y=%0d p2=%0d",
                 d_vals[i], x_pos, y_pos, pts2, exp_x[i], exp_y[i], exp_p2[i]);
      end
    end
  endtask

  task automatic test_top_wall();
    int ey;
    start_game(1'b1, 376, 376);
    repeat (81) frame();
    for (int k = 1; k <= 66; k++) begin
      frame();
      ey = (k <= 65) ? 376 - 5 * k : 56;
      n_tests++;
      if (y_pos !== 11'(ey) || x_pos !== 11'(908 - 5 * k)) begin
        n_fail++;
        $display("[TB] FAIL top_wall_k%0d: got x=%0d y=%0d expected x=%0d y=%0d", k, x_pos, y_pos, 908 - 5 * k, ey);
      end
    end
  endtask

  task automatic test_miss_and_serve();
    start_game(1'b1, 0, 350);
    repeat (81) frame();
    n_tests++; if (x_pos !== 11'd909) begin n_fail++; $display("[TB] FAIL miss_x: got %0d expected 909", x_pos); end
    n_tests++; if (pts2 !== 4'd1 || pts1 !== 4'd0) begin n_fail++; $display("[TB] FAIL miss_scores: got %0d/%0d expected 0/1", pts1, pts2); end
    repeat (21) frame();
    n_tests++; if (x_pos !== 11'd1014) begin n_fail++; $display("[TB] FAIL drift_x: got %0d expected 1014", x_pos); end
    end_of_frame = 1'b1;
    tick();
    end_of_frame = 1'b0;
    n_tests++; if (x_pos !== 11'd1017) begin n_fail++; $display("[TB] FAIL exit_clamp_x: got %0d expected 1017", x_pos); end
    tick();
    n_tests++; if (x_pos !== 11'd504 || y_pos !== 11'd376) begin n_fail++; $display("[TB] FAIL serve_centre: got %0d,%0d expected 504,376", x_pos, y_pos); end
    n_tests++; if (game_over !== 1'b0 || pts2 !== 4'd1) begin n_fail++; $display("[TB] FAIL serve_state: got over=%0d p2=%0d expected 0/1", game_over, pts2); end
    serve = 1'b1;
    tick();
    serve = 1'b0;
    repeat (3) frame();
    n_tests++; if (x_pos !== 11'(m_x) || y_pos !== 11'(m_y)) begin n_fail++; $display("[TB] FAIL reserve_motion: got %0d,%0d expected %0d,%0d", x_pos, y_pos, m_x, m_y); end
  endtask

  task automatic test_speed_ramp();
    int hits_seen, prev_dx, exp_step;
    hits_seen = 0;
    start_game(1'b0, 350, 0);
    for (int f = 0; f < 6000 && hits_seen < 20; f++) begin
      prev_dx = m_dx;
      frame();
      n_tests++;
      if (x_pos !== 11'(m_x) || y_pos !== 11'(m_y)) begin
        n_fail++;
        $display("[TB] FAIL ramp_f%0d: got %0d,%0d expected %0d,%0d", f, x_pos, y_pos, m_x, m_y);
      end
      if (prev_dx == 1 && m_dx == -1) begin
        hits_seen++;
        if (hits_seen == 3 || hits_seen == 4 || hits_seen == 16 || hits_seen == 20) begin
          frame();
          exp_step = (hits_seen == 3) ? 5 : (hits_seen == 4) ? 6 : 9;
          n_tests++;
          if (11'd908 - x_pos !== 11'(exp_step)) begin
            n_fail++;
            $display("[TB] FAIL ramp_speed_hit%0d: got %0d expected %0d", hits_seen, 11'd908 - x_pos, exp_step);
          end
        end
      end
    end
    n_tests++; if (hits_seen < 20) begin n_fail++; $display("[TB] FAIL ramp_timeout: got %0d hits expected 20", hits_seen); end
  endtask

  task automatic test_game_over();
    start_game(1'b1, 0, 350);
    serve = 1'b1;
    for (int f = 0; f < 3000 && game_over !== 1'b1; f++) begin
      frame();
      n_tests++;
      if (x_pos !== 11'(m_x) || y_pos !== 11'(m_y) || pts1 !== 4'(m_s1) || pts2 !== 4'(m_s2)) begin
        n_fail++;
        $display("[TB] FAIL match_f%0d: got %0d,%0d %0d/%0d expected %0d,%0d %0d/%0d",
                 f, x_pos, y_pos, pts1, pts2, m_x, m_y, m_s1, m_s2);
      end
    end
    n_tests++; if (pts2 !== 4'd11 || pts1 !== 4'd0) begin n_fail++; $display("[TB] FAIL final_scores: got %0d/%0d expected 0/11", pts1, pts2); end
    n_tests++; if (game_over !== 1'b1) begin n_fail++; $display("[TB] FAIL game_over: got %0d expected 1", game_over); end
    n_tests++; if (winner !== 1'b1) begin n_fail++; $display("[TB] FAIL winner: got %0d expected 1", winner); end
    repeat (10) frame();
    serve = 1'b0;
    n_tests++; if (x_pos !== 11'd1017 || y_pos !== 11'd376) begin n_fail++; $display("[TB] FAIL frozen_pos: got %0d,%0d expected 1017,376", x_pos, y_pos); end
    n_tests++; if (game_over !== 1'b1 || pts2 !== 4'd11) begin n_fail++; $display("[TB] FAIL frozen_state: got over=%0d p2=%0d expected 1/11", game_over, pts2); end
  endtask

  task automatic test_disable_midflight();
    start_game(1'b1, 0, 350);
    repeat (81) frame();
    n_tests++; if (pts2 !== 4'd1) begin n_fail++; $display("[TB] FAIL dis_pre_score: got %0d expected 1", pts2); end
    serve = 1'b1;
    repeat (30) frame();
    serve = 1'b0;
    game_enable = 1'b0;
    tick();
    n_tests++; if (x_pos !== 11'd504 || y_pos !== 11'd376) begin n_fail++; $display("[TB] FAIL dis_centre: got %0d,%0d expected 504,376", x_pos, y_pos); end
    n_tests++; if (pts1 !== 4'd0 || pts2 !== 4'd0 || game_over !== 1'b0) begin n_fail++; $display("[TB] FAIL dis_clear: got %0d/%0d over=%0d expected 0/0 over=0", pts1, pts2, game_over); end
    game_enable = 1'b1;
    tick();
    tick();
    serve = 1'b1;
    tick();
    serve = 1'b0;
    repeat (5) frame();
    n_tests++; if (x_pos !== 11'd529 || y_pos !== 11'd376) begin n_fail++; $display("[TB] FAIL dis_restart: got %0d,%0d expected 529,376", x_pos, y_pos); end
  endtask

  task automatic test_reset_midflight();
    start_game(1'b1, 0, 350);
    repeat (85) frame();
    n_tests++; if (x_pos !== 11'd929 || pts2 !== 4'd1) begin n_fail++; $display("[TB] FAIL rst_pre: got x=%0d p2=%0d expected 929/1", x_pos, pts2); end
    rst = 1'b1;
    end_of_frame = 1'b1;
    tick();
    rst = 1'b0;
    end_of_frame = 1'b0;
    n_tests++; if (x_pos !== 11'd504 || y_pos !== 11'd376) begin n_fail++; $display("[TB] FAIL rst_centre: got %0d,%0d expected 504,376", x_pos, y_pos); end
    n_tests++; if (pts1 !== 4'd0 || pts2 !== 4'd0) begin n_fail++; $display("[TB] FAIL rst_scores: got %0d/%0d expected 0/0", pts1, pts2); end
  endtask

  task automatic test_random();
    int v1, v2;
    start_game(1'b1, 350, 350);
    for (int c = 0; c < 4000; c++) begin
      end_of_frame = ($urandom_range(0, 3) != 0);
      serve        = ($urandom_range(0, 7) == 0);
      game_enable  = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 299) == 0) mode_multi = ~mode_multi;
      v1 = m_y + 15 - int'($urandom_range(0, 110));
      v2 = m_y + 15 - int'($urandom_range(0, 110));
      p1 = 10'((v1 < 0) ? 0 : v1);
      p2 = 10'((v2 < 0) ? 0 : v2);
      tick();
      n_tests++;
      if (x_pos !== 11'(m_x) || y_pos !== 11'(m_y) || pts1 !== 4'(m_s1) || pts2 !== 4'(m_s2) ||
          game_over !== 1'(m_over) || winner !== 1'(m_win)) begin
        n_fail++;
        $display("[TB] FAIL random_c%0d: got x=%0d y=%0d s=%0d/%0d over=%0d win=%0d expected x=%0d y=%0d s=%0d/%0d over=%0d win=%0d",
                 c, x_pos, y_pos, pts1, pts2, game_over, winner, m_x, m_y, m_s1, m_s2, m_over, m_win);
      end
    end
    end_of_frame = 1'b0;
    serve = 1'b0;
    game_enable = 1'b1;
  endtask

  // Scenario sequence and summary
  initial begin
    rst = 1'b1; end_of_frame = 1'b0; serve = 1'b0; game_enable = 1'b0;
    mode_multi = 1'b1; p1 = 10'd0; p2 = 10'd0;
    model_new_game();
    test_reset();
    test_right_hit();
    test_racket_zones();
    test_top_wall();
    test_miss_and_serve();
    test_speed_ramp();
    test_game_over();
    test_disable_midflight();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
